soc_freq_master: RTL and testbench

SOC_FREQ_MASTER -- requirements
Module: soc_freq_master

---
 rtl/soc_freq_master.sv | 248 ++++++++++++++++++++++++
 tb/tb_soc_freq_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_freq_master.sv
// soc_freq_master: command FIFO feeding an Avalon-MM write initiator.
// Commands {addr,data} are queued in a DEPTH-entry FIFO and issued one at a
// time as Avalon writes, with at least one idle cycle between transactions.
// Optional feature macro: SOC_FREQ_MASTER_VERIFY_EN -- when defined, every
// write is followed by a read of the same address; a readback that differs
// from the written data sets the sticky verify_err flag and bumps err_count.
module soc_freq_master #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_addr,
  input  logic [31:0]              cmd_data,
  output logic [1:0]               avm_address,
  output logic                     avm_chipselect,
  output logic                     avm_write_n,
  output logic                     avm_read_n,
  output logic [31:0]              avm_writedata,
  input  logic [31:0]              avm_readdata,
  input  logic                     avm_waitrequest,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     verify_err,
  output logic [7:0]               err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

`ifdef SOC_FREQ_MASTER_VERIFY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [1:0]    r_mem_addr [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_cmd_ready;
  logic [LW-1:0] w_level_nxt;
  logic          w_push;
  logic          w_pop;

  // FSM and registered bus outputs
  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_address;
  logic [1:0]    w_address_nxt;
  logic [31:0]   r_writedata;
  logic [31:0]   w_writedata_nxt;
  logic          r_cs;
  logic          w_cs_nxt;
  logic          r_wr_n;
  logic          w_wr_n_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic          r_busy;

  // A command is accepted only when the registered ready says there is room
  assign w_push = cmd_valid & r_cmd_ready;

  // Next FIFO occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + {{(LW-1){1'b0}}, 1'b1};
      2'b01:   w_level_nxt = r_level - {{(LW-1){1'b0}}, 1'b1};
      default: w_level_nxt = r_level;
    endcase
  end

  // FIFO pointers, level and ready; pointers wrap naturally at power-of-2 DEPTH
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_level     <= {LW{1'b0}};
      r_cmd_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      r_level     <= w_level_nxt;
      r_cmd_ready <= (w_level_nxt < DEPTH_L);
    end
  end

  // FIFO payload storage; contents are don't-care while the level says empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= cmd_addr;
      r_mem_data[r_wr_ptr] <= cmd_data;
    end
  end

`ifdef SOC_FREQ_MASTER_VERIFY_EN
  logic       r_rd_n;
  logic       w_rd_n_nxt;
  logic       w_err_set;
  logic       r_verify_err;
  logic [7:0] r_err_count;
`else
  logic [31:0] w_unused_rdata;
  assign w_unused_rdata = avm_readdata;
`endif

  // Next-state and next-output logic; bus outputs hold while waitrequest=1
  always_comb begin
    w_state_nxt     = r_state;
    w_address_nxt   = r_address;
    w_writedata_nxt = r_writedata;
    w_cs_nxt        = r_cs;
    w_wr_n_nxt      = r_wr_n;
    w_done_nxt      = 1'b0;
    w_pop           = 1'b0;
`ifdef SOC_FREQ_MASTER_VERIFY_EN
    w_rd_n_nxt      = r_rd_n;
    w_err_set       = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (r_level != {LW{1'b0}}) begin
          w_state_nxt     = ST_WRITE;
          w_address_nxt   = r_mem_addr[r_rd_ptr];
          w_writedata_nxt = r_mem_data[r_rd_ptr];
          w_cs_nxt        = 1'b1;
          w_wr_n_nxt      = 1'b0;
        end else begin
          w_cs_nxt        = 1'b0;
          w_wr_n_nxt      = 1'b1;
        end
      end
      ST_WRITE: begin
        if (!avm_waitrequest) begin
          w_pop      = 1'b1;
          w_wr_n_nxt = 1'b1;
`ifdef SOC_FREQ_MASTER_VERIFY_EN
          // Read back the same address before declaring the command done
          w_state_nxt = ST_READ;
          w_rd_n_nxt  = 1'b0;
`else
          w_state_nxt = ST_IDLE;
          w_cs_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
`endif
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
`ifdef SOC_FREQ_MASTER_VERIFY_EN
      ST_READ: begin
        if (!avm_waitrequest) begin
          w_state_nxt = ST_IDLE;
          w_cs_nxt    = 1'b0;
          w_rd_n_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
          w_err_set   = (avm_readdata != r_writedata);
        end else begin
          w_state_nxt = ST_READ;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_cs_nxt    = 1'b0;
        w_wr_n_nxt  = 1'b1;
`ifdef SOC_FREQ_MASTER_VERIFY_EN
        w_rd_n_nxt  = 1'b1;
`endif
      end
    endcase
  end

  // State register and registered outputs; reset aborts any transaction
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_address   <= 2'b00;
      r_writedata <= 32'h0000_0000;
      r_cs        <= 1'b0;
      r_wr_n      <= 1'b1;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_address   <= w_address_nxt;
      r_writedata <= w_writedata_nxt;
      r_cs        <= w_cs_nxt;
      r_wr_n      <= w_wr_n_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE) || (w_level_nxt != {LW{1'b0}});
    end
  end

`ifdef SOC_FREQ_MASTER_VERIFY_EN
  // Read strobe plus sticky mismatch flag and saturating mismatch counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_n       <= 1'b1;
      r_verify_err <= 1'b0;
      r_err_count  <= 8'h00;
    end else begin
      r_rd_n <= w_rd_n_nxt;
      if (w_err_set) begin
        r_verify_err <= 1'b1;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'h01;
        end
      end
    end
  end

  assign avm_read_n = r_rd_n;
  assign verify_err = r_verify_err;
  assign err_count  = r_err_count;
`else
  assign avm_read_n = 1'b1;
  assign verify_err = 1'b0;
  assign err_count  = 8'h00;
`endif

  assign cmd_ready      = r_cmd_ready;
  assign level          = r_level;
  assign avm_address    = r_address;
  assign avm_writedata  = r_writedata;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wr_n;
  assign done           = r_done;
  assign busy           = r_busy;

endmodule

// File: tb/tb_soc_freq_master.sv
// Testbench for soc_freq_master: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level queue model.
module tb_soc_freq_master;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef SOC_FREQ_MASTER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_addr;
  logic [31:0]   cmd_data;
  logic [1:0]    avm_address;
  logic          avm_chipselect;
  logic          avm_write_n;
  logic          avm_read_n;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata;
  logic          avm_waitrequest;
  logic          busy;
  logic          done;
  logic [LW-1:0] level;
  logic          verify_err;
  logic [7:0]    err_count;

  soc_freq_master #(.DEPTH(DEPTH)) u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_addr        (cmd_addr),
    .cmd_data        (cmd_data),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write_n     (avm_write_n),
    .avm_read_n      (avm_read_n),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .level           (level),
    .verify_err      (verify_err),
    .err_count       (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Single comparison point: counts every check and reports mismatches
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of pending commands plus a transaction phase
  // (0 idle, 1 write on bus, 2 read-back on bus)
  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
  } cmd_t;

  cmd_t        m_q[$];
  int          m_phase = 0;
  logic [1:0]  m_addr  = 2'b00;
  logic [31:0] m_data  = 32'h0;
  bit          m_done  = 1'b0;
  bit          m_err   = 1'b0;
  int          m_cnt   = 0;
  bit          m_rdy   = 1'b0;
  bit          rd_bad  = 1'b0;

  // Advance the model by one clock edge using the inputs presented to it
  task automatic model_step();
    bit   push;
    bit   pop;
    cmd_t c;
    if (!reset_n) begin
      m_q.delete();
      m_phase = 0;
      m_addr  = 2'b00;
      m_data  = 32'h0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_cnt   = 0;
      m_rdy   = 1'b0;
    end else begin
      push   = cmd_valid && m_rdy;
      pop    = 1'b0;
      c.a    = cmd_addr;
      c.d    = cmd_data;
      m_done = 1'b0;
      case (m_phase)
        0: if (m_q.size() > 0) begin
             m_phase = 1;
             m_addr  = m_q[0].a;
             m_data  = m_q[0].d;
           end
        1: if (!avm_waitrequest) begin
             pop = 1'b1;
             if (VERIFY) m_phase = 2;
             else begin
               m_phase = 0;
               m_done  = 1'b1;
             end
           end
        2: if (!avm_waitrequest) begin
             m_phase = 0;
             m_done  = 1'b1;
             if (avm_readdata !== m_data) begin
               m_err = 1'b1;
               if (m_cnt < 255) m_cnt++;
             end
           end
        default: m_phase = 0;
      endcase
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(c);
      m_rdy = (m_q.size() < DEPTH);
    end
  endtask

  task automatic check_outputs();
    check_val("cmd_ready",  {31'h0, cmd_ready},      {31'h0, m_rdy});
    check_val("level",      32'(level),              32'(m_q.size()));
    check_val("chipselect", {31'h0, avm_chipselect}, {31'h0, m_phase != 0});
    check_val("write_n",    {31'h0, avm_write_n},    {31'h0, m_phase != 1});
    check_val("read_n",     {31'h0, avm_read_n},     {31'h0, m_phase != 2});
    check_val("address",    {30'h0, avm_address},    {30'h0, m_addr});
    check_val("writedata",  avm_writedata,           m_data);
    check_val("done",       {31'h0, done},           {31'h0, m_done});
    check_val("busy",       {31'h0, busy},           {31'h0, (m_phase != 0) || (m_q.size() > 0)});
    check_val("verify_err", {31'h0, verify_err},     {31'h0, m_err});
    check_val("err_count",  {24'h0, err_count},      32'(m_cnt));
    check_val("rw_excl",    {31'h0, avm_write_n | avm_read_n}, 32'h1);
  endtask

  // Present inputs for the next edge; the responder reflects written data
  // back, corrupted in bit 0 when rd_bad is set
  task automatic drive(input bit v, input logic [1:0] a, input logic [31:0] d, input bit w);
    cmd_valid       = v;
    cmd_addr        = a;
    cmd_data        = d;
    avm_waitrequest = w;
    avm_readdata    = m_data ^ {31'h0, rd_bad};
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    repeat (2) cycle();
    reset_n = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    cycle();

    // Single write with zero wait
    drive(1'b1, 2'd0, 32'h0000_1B4A, 1'b0);
    cycle();
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    repeat (5) cycle();

    // Write stretched by five waitrequest cycles
    drive(1'b1, 2'd1, 32'hCAFE_0001, 1'b1);
    cycle();
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    repeat (5) cycle();
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    repeat (5) cycle();

    // Fill the FIFO behind a stalled write, then drain across the wrap
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 2'(i), 32'hA000_0000 + 32'(i), 1'b1);
      cycle();
    end
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    repeat (14) cycle();

    // Reset in the middle of a write with entries queued
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 32'hB000_0000 + 32'(i), 1'b1);
      cycle();
    end
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    repeat (5) cycle();

    // Push landing on the same edge as the pop at level 1
    drive(1'b1, 2'd2, 32'hC000_000A, 1'b0);
    cycle();
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 2'd3, 32'hC000_000B, 1'b0);
    cycle();
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    repeat (6) cycle();

`ifdef SOC_FREQ_MASTER_VERIFY_EN
    // Corrupted readback followed by a clean one
    rd_bad = 1'b1;
    drive(1'b1, 2'd0, 32'h0000_0370, 1'b0);
    cycle();
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    repeat (5) cycle();
    rd_bad = 1'b0;
    drive(1'b1, 2'd1, 32'h0000_0371, 1'b0);
    cycle();
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    repeat (5) cycle();
`endif

    // Random traffic with random stalls, bad readbacks and rare resets
    for (int i = 0; i < 800; i++) begin
      rd_bad  = ($urandom_range(0, 3) == 0);
      reset_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 99) < 55, 2'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 2) == 0);
      cycle();
    end
    reset_n = 1'b1;
    rd_bad  = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    repeat (20) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
